// File: rtl/unified_mem_arbiter_pkg.sv
// unified_mem_arbiter_pkg: shared state encoding and constants for the unified memory arbiter
package unified_mem_arbiter_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY_I = 2'd1, BUSY_D = 2'd2} state_t;
  localparam logic [3:0] BE_WORD = 4'hF;
  localparam int ADDR_W_DEF = 12;
endpackage

// File: rtl/unified_mem_arbiter_if.sv
// unified_mem_arbiter_if: single-ported memory bus between the arbiter (master) and the memory (slave)
interface unified_mem_arbiter_if
  import unified_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = 32
);
  logic              mem_en;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  modport master (output mem_en, mem_we, mem_be, mem_addr, mem_wdata, input mem_rdata, mem_ack);
  modport slave (input mem_en, mem_we, mem_be, mem_addr, mem_wdata, output mem_rdata, mem_ack);
endinterface

// File: rtl/unified_mem_arbiter_starve_counter.sv
// arb_starve_counter: saturating count of data grants taken while fetch waits
module arb_starve_counter #(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic at_max
);
  logic [3:0] cnt;
  always_ff @(posedge clk)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc && !at_max) cnt <= cnt + 4'd1;
  assign at_max = cnt == 4'(MAX);
endmodule

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one single-ported memory between fetch and load/store with data priority and fetch anti-starvation
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_valid,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_valid,
  input  logic              d_we,
  input  logic [3:0]        d_be,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic              stall_if,
  output logic              stall_mem,
  unified_mem_arbiter_if.master bus
);
  state_t state, state_n;
  logic at_max, accept, grant_d, grant_i, done;
  assign accept  = state == IDLE && !if_ready && !d_ready;
  assign grant_d = accept && d_valid && !(if_valid && at_max);
  assign grant_i = accept && if_valid && !grant_d;
  assign done    = state != IDLE && bus.mem_en && bus.mem_ack;
  assign stall_if  = if_valid && !if_ready;
  assign stall_mem = d_valid && !d_ready;
  arb_starve_counter #(.MAX(STARVE_MAX)) u_starve (
    .clk(clk),
    .rst_n(rst_n),
    .inc(grant_d && if_valid),
    .clr(grant_i),
    .at_max(at_max)
  );
  always_comb begin
    state_n = state;
    if (state == IDLE) state_n = grant_d ? BUSY_D : grant_i ? BUSY_I : IDLE;
    else if (done) state_n = IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      if_ready      <= 1'b0;
      d_ready       <= 1'b0;
      if_rdata      <= '0;
      d_rdata       <= '0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_be    <= '0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      state    <= state_n;
      if_ready <= done && state == BUSY_I;
      d_ready  <= done && state == BUSY_D;
      if (grant_d || grant_i) begin
        bus.mem_en    <= 1'b1;
        bus.mem_we    <= grant_d && d_we;
        bus.mem_be    <= grant_d ? d_be : BE_WORD;
        bus.mem_addr  <= grant_d ? d_addr : if_addr;
        bus.mem_wdata <= grant_d ? d_wdata : '0;
      end
      if (done) bus.mem_en <= 1'b0;
      if (done && state == BUSY_I) if_rdata <= bus.mem_rdata;
      if (done && state == BUSY_D && !bus.mem_we) d_rdata <= bus.mem_rdata;
    end
  end
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: directed self-checking bench for unified_mem_arbiter
module tb_unified_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_valid = 1'b0;
  logic [11:0] if_addr = '0;
  logic        if_ready;
  logic [31:0] if_rdata;
  logic        d_valid = 1'b0;
  logic        d_we = 1'b0;
  logic [3:0]  d_be = 4'hF;
  logic [11:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic        stall_if;
  logic        stall_mem;
  int errors = 0;
  int checks = 0;
  logic [31:0] exp_drdata;
  unified_mem_arbiter_if #(.ADDR_W(12), .DATA_W(32)) bus ();
  unified_mem_arbiter #(.ADDR_W(12), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .if_valid(if_valid),
    .if_addr(if_addr),
    .if_ready(if_ready),
    .if_rdata(if_rdata),
    .d_valid(d_valid),
    .d_we(d_we),
    .d_be(d_be),
    .d_addr(d_addr),
    .d_wdata(d_wdata),
    .d_ready(d_ready),
    .d_rdata(d_rdata),
    .stall_if(stall_if),
    .stall_mem(stall_mem),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic idle(input int n);
    if_valid = 1'b0;
    d_valid = 1'b0;
    bus.mem_ack = 1'b0;
    repeat (n) step();
  endtask
  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    if_valid = 1'b1;
    if_addr = 12'h020;
    d_valid = 1'b1;
    d_we = 1'b0;
    d_be = 4'hF;
    d_addr = 12'h010;
    repeat (2) step();
    checks++; if (bus.mem_en !== 1'b0) begin errors++; $display("FAIL reset_mem_en: got %b want 0", bus.mem_en); end
    checks++; if (if_ready !== 1'b0 || d_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got if=%b d=%b want 0 0", if_ready, d_ready); end
    checks++; if (stall_if !== 1'b1) begin errors++; $display("FAIL reset_stall_if: got %b want 1", stall_if); end
    checks++; if (if_rdata !== 32'h0 || d_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h %h want 0 0", if_rdata, d_rdata); end
    rst_n = 1'b1;
    step();
    checks++; if (bus.mem_en !== 1'b1 || bus.mem_addr !== 12'h010) begin errors++; $display("FAIL reset_first_grant: got en=%b addr=%h want 1 010", bus.mem_en, bus.mem_addr); end
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 32'h1111_2222;
    exp_drdata = 32'h1111_2222;
    step();
    checks++; if (d_ready !== 1'b1 || d_rdata !== exp_drdata) begin errors++; $display("FAIL reset_first_done: got rdy=%b data=%h want 1 %h", d_ready, d_rdata, exp_drdata); end
    idle(3);
  endtask
  task automatic test_stray_ack();
    bus.mem_ack = 1'b1;
    repeat (2) step();
    checks++; if (bus.mem_en !== 1'b0 || if_ready !== 1'b0 || d_ready !== 1'b0) begin errors++; $display("FAIL stray_ack: got en=%b if=%b d=%b want 0 0 0", bus.mem_en, if_ready, d_ready); end
    bus.mem_ack = 1'b0;
  endtask
  task automatic test_fetch();
    if_valid = 1'b1;
    if_addr = 12'h004;
    step();
    checks++; if (bus.mem_en !== 1'b1 || bus.mem_addr !== 12'h004 || bus.mem_be !== 4'hF || bus.mem_we !== 1'b0) begin errors++; $display("FAIL fetch_bus: got en=%b addr=%h be=%h we=%b want 1 004 f 0", bus.mem_en, bus.mem_addr, bus.mem_be, bus.mem_we); end
    checks++; if (if_ready !== 1'b0 || stall_if !== 1'b1) begin errors++; $display("FAIL fetch_wait: got rdy=%b stall=%b want 0 1", if_ready, stall_if); end
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 32'h0010_0093;
    step();
    checks++; if (if_ready !== 1'b1 || if_rdata !== 32'h0010_0093 || stall_if !== 1'b0) begin errors++; $display("FAIL fetch_done: got rdy=%b data=%h stall=%b want 1 00100093 0", if_ready, if_rdata, stall_if); end
    checks++; if (bus.mem_en !== 1'b0) begin errors++; $display("FAIL fetch_en_drop: got %b want 0", bus.mem_en); end
    if_valid = 1'b0;
    bus.mem_ack = 1'b0;
    step();
    checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL fetch_pulse_width: got %b want 0", if_ready); end
    idle(2);
  endtask
  task automatic test_tie();
    if_valid = 1'b1;
    if_addr = 12'h080;
    d_valid = 1'b1;
    d_we = 1'b0;
    d_be = 4'hF;
    d_addr = 12'h000;
    step();
    checks++; if (bus.mem_addr !== 12'h000 || bus.mem_we !== 1'b0 || stall_if !== 1'b1) begin errors++; $display("FAIL tie_data_first: got addr=%h we=%b stall_if=%b want 000 0 1", bus.mem_addr, bus.mem_we, stall_if); end
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 32'hFFFF_FB2E;
    exp_drdata = 32'hFFFF_FB2E;
    step();
    checks++; if (d_ready !== 1'b1 || d_rdata !== exp_drdata) begin errors++; $display("FAIL tie_data_done: got rdy=%b data=%h want 1 %h", d_ready, d_rdata, exp_drdata); end
    d_valid = 1'b0;
    bus.mem_ack = 1'b0;
    step();
    checks++; if (bus.mem_en !== 1'b0) begin errors++; $display("FAIL tie_bubble: got en=%b want 0", bus.mem_en); end
    step();
    checks++; if (bus.mem_en !== 1'b1 || bus.mem_addr !== 12'h080) begin errors++; $display("FAIL tie_fetch_second: got en=%b addr=%h want 1 080", bus.mem_en, bus.mem_addr); end
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 32'h0000_0013;
    step();
    checks++; if (if_ready !== 1'b1 || if_rdata !== 32'h0000_0013) begin errors++; $display("FAIL tie_fetch_done: got rdy=%b data=%h want 1 00000013", if_ready, if_rdata); end
    idle(2);
  endtask
  task automatic test_starvation();
    if_valid = 1'b1;
    if_addr = 12'h100;
    d_valid = 1'b1;
    d_we = 1'b0;
    d_be = 4'hF;
    for (int k = 0; k < 4; k++) begin
      d_addr = 12'h200 + 12'(4 * k);
      step();
      checks++; if (bus.mem_addr !== 12'h200 + 12'(4 * k)) begin errors++; $display("FAIL starve_data_grant%0d: got addr=%h want %h", k, bus.mem_addr, 12'h200 + 12'(4 * k)); end
      bus.mem_ack = 1'b1;
      bus.mem_rdata = 32'hA000_0000 + 32'(k);
      exp_drdata = 32'hA000_0000 + 32'(k);
      step();
      bus.mem_ack = 1'b0;
      d_addr = 12'h210;
      step();
    end
    step();
    checks++; if (bus.mem_addr !== 12'h100 || bus.mem_we !== 1'b0 || bus.mem_be !== 4'hF) begin errors++; $display("FAIL starve_fetch_grant: got addr=%h we=%b be=%h want 100 0 f", bus.mem_addr, bus.mem_we, bus.mem_be); end
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 32'h0000_0033;
    step();
    checks++; if (if_ready !== 1'b1 || d_rdata !== exp_drdata) begin errors++; $display("FAIL starve_fetch_done: got rdy=%b d_rdata=%h want 1 %h", if_ready, d_rdata, exp_drdata); end
    bus.mem_ack = 1'b0;
    if_addr = 12'h104;
    step();
    step();
    checks++; if (bus.mem_addr !== 12'h210) begin errors++; $display("FAIL starve_counter_clear: got addr=%h want 210", bus.mem_addr); end
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 32'h0BAD_F00D;
    exp_drdata = 32'h0BAD_F00D;
    step();
    idle(3);
  endtask
  task automatic test_store();
    d_valid = 1'b1;
    d_we = 1'b1;
    d_be = 4'b0010;
    d_addr = 12'h015;
    d_wdata = 32'h0000_1400;
    step();
    for (int c = 0; c < 4; c++) begin
      checks++; if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_be !== 4'b0010 || bus.mem_addr !== 12'h015 || bus.mem_wdata !== 32'h0000_1400 || d_ready !== 1'b0) begin errors++; $display("FAIL store_stable%0d: got en=%b we=%b be=%h addr=%h wd=%h rdy=%b want 1 1 2 015 00001400 0", c, bus.mem_en, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata, d_ready); end
      if (c == 3) begin
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 32'hDEAD_BEEF;
      end
      step();
    end
    checks++; if (d_ready !== 1'b1 || d_rdata !== exp_drdata) begin errors++; $display("FAIL store_done: got rdy=%b d_rdata=%h want 1 %h", d_ready, d_rdata, exp_drdata); end
    d_valid = 1'b0;
    bus.mem_ack = 1'b0;
    step();
    checks++; if (d_ready !== 1'b0 || bus.mem_en !== 1'b0) begin errors++; $display("FAIL store_once: got rdy=%b en=%b want 0 0", d_ready, bus.mem_en); end
    d_we = 1'b0;
    idle(2);
  endtask
  task automatic test_reset_mid();
    d_valid = 1'b1;
    d_we = 1'b0;
    d_be = 4'hF;
    d_addr = 12'h040;
    step();
    checks++; if (bus.mem_en !== 1'b1) begin errors++; $display("FAIL midrst_busy: got en=%b want 1", bus.mem_en); end
    rst_n = 1'b0;
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 32'h5555_AAAA;
    step();
    checks++; if (bus.mem_en !== 1'b0 || d_ready !== 1'b0 || d_rdata !== 32'h0) begin errors++; $display("FAIL midrst_clear: got en=%b rdy=%b data=%h want 0 0 0", bus.mem_en, d_ready, d_rdata); end
    rst_n = 1'b1;
    d_valid = 1'b0;
    step();
    step();
    checks++; if (bus.mem_en !== 1'b0 || d_ready !== 1'b0) begin errors++; $display("FAIL midrst_late_ack: got en=%b rdy=%b want 0 0", bus.mem_en, d_ready); end
    idle(2);
  endtask
  initial begin
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    exp_drdata = '0;
    test_reset();
    test_stray_ack();
    test_fetch();
    test_tie();
    test_starvation();
    test_store();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
